// File: rtl/timer_tima_if.sv
//============================================================================
// Module      : timer_tima_if
// Description : CPU decode/strobe, divider tap and interrupt signals shared
//               between the timer block and the surrounding core.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

interface timer_tima_if;
    logic       ff04_ff07;
    logic [1:0] a;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       div_4096hz;
    logic       div_262144hz;
    logic       div_65536hz;
    logic       div_16384hz;
    logic       int_timer;
    logic       tima_reload;

    modport master (
        output ff04_ff07, a, cpu_wr, cpu_rd,
        output div_4096hz, div_262144hz, div_65536hz, div_16384hz,
        input  int_timer, tima_reload
    );

    modport slave (
        input  ff04_ff07, a, cpu_wr, cpu_rd,
        input  div_4096hz, div_262144hz, div_65536hz, div_16384hz,
        output int_timer, tima_reload
    );
endinterface

`default_nettype wire

// File: rtl/timer_tima.sv
//============================================================================
// Module      : timer_tima
// Description : DMG TIMA/TMA/TAC timer with delayed overflow reload and
//               one-cycle timer interrupt request.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module timer_tima (
    input  wire        clk4,
    input  wire        nreset,
    timer_tima_if.slave bus,
    inout  wire  [7:0] d
);

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_pend   = 2'd1;
    localparam logic [1:0] c_st_reload = 2'd2;

    logic [7:0] r_tima;
    logic [7:0] r_tma;
    logic [2:0] r_tac;
    logic       r_tap_prev;
    logic [1:0] r_state;
    logic [1:0] r_pend_cnt;

    logic [7:0] w_tima_nxt;
    logic [1:0] w_state_nxt;
    logic [1:0] w_pend_nxt;
    logic       w_tap_sel;
    logic       w_tap_en;
    logic       w_inc;
    logic       w_wr;
    logic       w_wr_tima;
    logic       w_wr_tma;
    logic       w_wr_tac;
    logic [7:0] w_tma_next;
    logic       w_rd_en;
    logic [7:0] w_rd_data;

    always_comb begin
        case (r_tac[1:0])
            2'b00:   w_tap_sel = bus.div_4096hz;
            2'b01:   w_tap_sel = bus.div_262144hz;
            2'b10:   w_tap_sel = bus.div_65536hz;
            default: w_tap_sel = bus.div_16384hz;
        endcase
    end

    // Gating by the enable bit before edge detection is what makes a disable
    // or tap switch while the tap is high count as a falling edge.
    assign w_tap_en  = w_tap_sel & r_tac[2];
    assign w_inc     = r_tap_prev & ~w_tap_en;

    assign w_wr      = bus.ff04_ff07 & bus.cpu_wr & (bus.a != 2'b00);
    assign w_wr_tima = w_wr & (bus.a == 2'b01);
    assign w_wr_tma  = w_wr & (bus.a == 2'b10);
    assign w_wr_tac  = w_wr & (bus.a == 2'b11);
    assign w_tma_next = w_wr_tma ? d : r_tma;

    always_comb begin
        w_tima_nxt  = r_tima;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_cnt;
        case (r_state)
            c_st_run: begin
                if (w_wr_tima) begin
                    w_tima_nxt = d;
                end else if (w_inc) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_nxt  = 8'h00;
                        w_pend_nxt  = 2'd0;
                        w_state_nxt = c_st_pend;
                    end else begin
                        w_tima_nxt = r_tima + 8'd1;
                    end
                end
            end
            c_st_pend: begin
                w_pend_nxt = r_pend_cnt + 2'd1;
                // A TIMA write during the delay window cancels the reload.
                if (w_wr_tima) begin
                    w_tima_nxt  = d;
                    w_state_nxt = c_st_run;
                end else begin
                    if (w_inc) begin
                        w_tima_nxt = r_tima + 8'd1;
                    end
                    if (r_pend_cnt == 2'd3) begin
                        w_state_nxt = c_st_reload;
                    end
                end
            end
            c_st_reload: begin
                w_tima_nxt  = w_tma_next;
                w_state_nxt = c_st_run;
            end
            default: begin
                w_state_nxt = c_st_run;
            end
        endcase
    end

    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            r_tima     <= 8'h00;
            r_tma      <= 8'h00;
            r_tac      <= 3'b000;
            r_tap_prev <= 1'b0;
            r_state    <= c_st_run;
            r_pend_cnt <= 2'd0;
        end else begin
            r_tima     <= w_tima_nxt;
            r_state    <= w_state_nxt;
            r_pend_cnt <= w_pend_nxt;
            r_tap_prev <= w_tap_en;
            if (w_wr_tma) begin
                r_tma <= d;
            end
            if (w_wr_tac) begin
                r_tac <= d[2:0];
            end
        end
    end

    assign bus.int_timer   = (r_state == c_st_reload);
    assign bus.tima_reload = (r_state == c_st_reload);

    assign w_rd_en = bus.ff04_ff07 & bus.cpu_rd & (bus.a != 2'b00);

    always_comb begin
        case (bus.a)
            2'b01:   w_rd_data = r_tima;
            2'b10:   w_rd_data = r_tma;
            default: w_rd_data = {5'b11111, r_tac};
        endcase
    end

    assign d = w_rd_en ? w_rd_data : 8'hzz;

endmodule

`default_nettype wire
